// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC, imem req/ready handshake, IF/ID register and a one-word hold buffer.
// Optional FETCH_REDIRECT_CNT_EN adds a saturating 16-bit redirect counter output.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [25:0] jump_index,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc_plus4,
  output logic        if_valid,
  output logic [5:0]  opcode
`ifdef FETCH_REDIRECT_CNT_EN
  ,
  output logic [15:0] redirect_cnt
`endif
);

  typedef enum logic [1:0] {FETCH, WAIT, HOLD, DROP} state_t;

  state_t      state_reg;
  logic [31:0] pc_reg;
  logic [31:0] hold_buf_reg;
  logic [31:0] redir_pc_reg;
  logic [31:0] pc_plus4;
  logic [31:0] target;
  logic        redirect;
  logic        accept;

  assign redirect  = branch_taken | jump;
  assign target    = branch_taken ? branch_target : {if_pc_plus4[31:28], jump_index, 2'b00};
  assign pc_plus4  = pc_reg + 32'd4;
  assign imem_addr = pc_reg;
  assign accept    = imem_req & imem_ready;
  assign opcode    = if_instr[31:26];

  // Outstanding requests (WAIT/DROP) must keep req high until ready.
  always_comb begin
    imem_req = 1'b0;
    case (state_reg)
      FETCH:      imem_req = !stall;
      WAIT, DROP: imem_req = 1'b1;
      default:    imem_req = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg    <= FETCH;
      pc_reg       <= RESET_PC;
      hold_buf_reg <= 32'd0;
      redir_pc_reg <= 32'd0;
      if_instr     <= 32'd0;
      if_pc_plus4  <= 32'd0;
      if_valid     <= 1'b0;
    end else begin
      if (redirect) begin
        if_valid <= 1'b0;
        if_instr <= 32'd0;
      end
      case (state_reg)
        FETCH: begin
          if (redirect) begin
            if (imem_req && !imem_ready) begin
              redir_pc_reg <= target;
              state_reg    <= DROP;
            end else begin
              pc_reg <= target;
            end
          end else if (accept) begin
            if_instr    <= imem_rdata;
            if_pc_plus4 <= pc_plus4;
            if_valid    <= 1'b1;
            pc_reg      <= pc_plus4;
          end else if (imem_req) begin
            if_valid  <= 1'b0;
            state_reg <= WAIT;
          end
        end
        WAIT: begin
          if (redirect) begin
            if (imem_ready) begin
              pc_reg    <= target;
              state_reg <= FETCH;
            end else begin
              redir_pc_reg <= target;
              state_reg    <= DROP;
            end
          end else if (imem_ready) begin
            pc_reg <= pc_plus4;
            if (stall) begin
              hold_buf_reg <= imem_rdata;
              state_reg    <= HOLD;
            end else begin
              if_instr    <= imem_rdata;
              if_pc_plus4 <= pc_plus4;
              if_valid    <= 1'b1;
              state_reg   <= FETCH;
            end
          end else if (!stall) begin
            if_valid <= 1'b0;
          end
        end
        HOLD: begin
          if (redirect) begin
            pc_reg    <= target;
            state_reg <= FETCH;
          end else if (!stall) begin
            // pc already advanced past the held word, so it is that word's PC+4.
            if_instr    <= hold_buf_reg;
            if_pc_plus4 <= pc_reg;
            if_valid    <= 1'b1;
            state_reg   <= FETCH;
          end
        end
        DROP: begin
          if (imem_ready) begin
            pc_reg    <= redirect ? target : redir_pc_reg;
            state_reg <= FETCH;
          end else if (redirect) begin
            redir_pc_reg <= target;
          end
        end
        default: state_reg <= FETCH;
      endcase
    end
  end

`ifdef FETCH_REDIRECT_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      redirect_cnt <= 16'd0;
    end else if (redirect && (redirect_cnt != 16'hFFFF)) begin
      redirect_cnt <= redirect_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios plus random stimulus against a transaction-level model.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = 32'd0;
  logic        jump = 1'b0;
  logic [25:0] jump_index = 26'd0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b0;
  logic [31:0] imem_rdata = 32'd0;
  logic [31:0] if_instr;
  logic [31:0] if_pc_plus4;
  logic        if_valid;
  logic [5:0]  opcode;
`ifdef FETCH_REDIRECT_CNT_EN
  logic [15:0] redirect_cnt;
`endif

  always #5 clk = ~clk;

  fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .stall        (stall),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .jump         (jump),
    .jump_index   (jump_index),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ready   (imem_ready),
    .imem_rdata   (imem_rdata),
    .if_instr     (if_instr),
    .if_pc_plus4  (if_pc_plus4),
    .if_valid     (if_valid),
    .opcode       (opcode)
`ifdef FETCH_REDIRECT_CNT_EN
    ,
    .redirect_cnt (redirect_cnt)
`endif
  );

  int errors = 0;
  int checks = 0;
  bit verbose = 1'b1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Transaction-level model: next fetch address, an outstanding request
  // (possibly doomed), an optional parked word, and the IF/ID contents.
  logic [31:0] m_pc = 32'd0;
  logic        m_busy = 1'b0;
  logic        m_dead = 1'b0;
  logic [31:0] m_dead_tgt = 32'd0;
  logic        m_parked = 1'b0;
  logic [31:0] m_park_word = 32'd0;
  logic [31:0] m_park_pc4 = 32'd0;
  logic [31:0] m_instr = 32'd0;
  logic [31:0] m_pc4 = 32'd0;
  logic        m_valid = 1'b0;
  int          m_cnt = 0;

  task automatic step(input logic s, input logic r, input logic b, input logic [31:0] bt,
                      input logic j, input logic [25:0] ji, input logic [31:0] rd, input logic rn);
    logic        exp_req;
    logic        redir;
    logic [31:0] tgt;
    @(negedge clk);
    rst_n = rn; stall = s; imem_ready = r; branch_taken = b; branch_target = bt;
    jump = j; jump_index = ji; imem_rdata = rd;
    #1;
    exp_req = m_parked ? 1'b0 : (m_busy ? 1'b1 : !s);
    if (rn) begin
      check("imem_req", 32'(imem_req), 32'(exp_req));
      check("imem_addr", imem_addr, m_pc);
    end
    redir = b | j;
    tgt = b ? bt : {m_pc4[31:28], ji, 2'b00};
    if (!rn) begin
      m_pc = 32'd0; m_busy = 0; m_dead = 0; m_parked = 0;
      m_instr = 32'd0; m_pc4 = 32'd0; m_valid = 0; m_cnt = 0;
    end else begin
      if (redir && m_cnt < 65535) m_cnt++;
      if (redir) begin
        m_valid = 0; m_instr = 32'd0; m_parked = 0;
        if (exp_req && !r) begin
          m_busy = 1; m_dead = 1; m_dead_tgt = tgt;
        end else begin
          m_pc = tgt; m_busy = 0; m_dead = 0;
        end
      end else if (m_dead) begin
        if (r) begin
          m_pc = m_dead_tgt; m_busy = 0; m_dead = 0;
        end
      end else if (m_parked) begin
        if (!s) begin
          m_instr = m_park_word; m_pc4 = m_park_pc4; m_valid = 1; m_parked = 0;
        end
      end else if (exp_req && r) begin
        if (s) begin
          m_parked = 1; m_park_word = rd; m_park_pc4 = m_pc + 32'd4;
        end else begin
          m_instr = rd; m_pc4 = m_pc + 32'd4; m_valid = 1;
        end
        m_pc = m_pc + 32'd4;
        m_busy = 0;
      end else if (exp_req) begin
        m_busy = 1;
        if (!s) m_valid = 0;
      end
    end
    @(posedge clk);
    #1;
    check("if_instr", if_instr, m_instr);
    check("if_pc_plus4", if_pc_plus4, m_pc4);
    check("if_valid", 32'(if_valid), 32'(m_valid));
    check("opcode", 32'(opcode), 32'(m_instr[31:26]));
`ifdef FETCH_REDIRECT_CNT_EN
    check("redirect_cnt", 32'(redirect_cnt), 32'(m_cnt));
`endif
    if (verbose)
      $display("step rst_n=%0b stall=%0b ready=%0b redir=%0b -> addr=%h req=%0b if_valid=%0b if_instr=%h pc4=%h",
               rn, s, r, redir, imem_addr, imem_req, if_valid, if_instr, if_pc_plus4);
  endtask

  initial begin
    // Reset
    step(0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    check("rst_addr", imem_addr, 32'h0);
    check("rst_valid", 32'(if_valid), 32'h0);
    check("rst_instr", if_instr, 32'h0);

    // Zero-wait streaming
    for (int k = 0; k < 4; k++) begin
      step(0, 1, 0, 0, 0, 0, 32'h0400_0000 | 32'(k * 4), 1);
      check("seq_addr", imem_addr, 32'((k + 1) * 4));
      check("seq_pc4", if_pc_plus4, 32'((k + 1) * 4));
      check("seq_opcode", 32'(opcode), 32'h01);
    end

    // Jump from ID with if_pc_plus4 = 0x00400008
    step(0, 1, 1, 32'h0040_0004, 0, 0, 32'h1111_1111, 1);
    step(0, 1, 0, 0, 0, 0, 32'h0800_0010, 1);
    check("jmp_pc4", if_pc_plus4, 32'h0040_0008);
    step(0, 1, 0, 0, 1, 26'h10, 32'h2222_2222, 1);
    check("jmp_addr", imem_addr, 32'h0000_0040);
    check("jmp_flush_v", 32'(if_valid), 32'h0);
    check("jmp_flush_i", if_instr, 32'h0);

    // Branch wins over jump
    step(0, 1, 1, 32'h0000_0100, 1, 26'h3FF, 32'h3333_3333, 1);
    check("br_prio_addr", imem_addr, 32'h0000_0100);

    // Wait states, stall on response -> hold, then release
    step(0, 0, 0, 0, 0, 0, 32'h0, 1);
    step(0, 0, 0, 0, 0, 0, 32'h0, 1);
    step(0, 0, 0, 0, 0, 0, 32'h0, 1);
    check("wait_addr", imem_addr, 32'h0000_0100);
    step(1, 1, 0, 0, 0, 0, 32'hDEAD_BEEF, 1);
    check("hold_addr", imem_addr, 32'h0000_0104);
    check("hold_req", 32'(imem_req), 32'h0);
    step(1, 0, 0, 0, 0, 0, 32'h0, 1);
    step(0, 0, 0, 0, 0, 0, 32'h0, 1);
    check("rel_instr", if_instr, 32'hDEAD_BEEF);
    check("rel_pc4", if_pc_plus4, 32'h0000_0104);
    check("rel_valid", 32'(if_valid), 32'h1);

    // Redirect while a request is pending -> drop its data
    step(0, 1, 1, 32'h0000_0010, 0, 0, 32'h0, 1);
    step(0, 0, 0, 0, 0, 0, 32'h0, 1);
    step(0, 0, 1, 32'h0000_0200, 0, 0, 32'h0, 1);
    check("drop_addr", imem_addr, 32'h0000_0010);
    step(0, 0, 0, 0, 0, 0, 32'h0, 1);
    step(0, 1, 0, 0, 0, 0, 32'h1234_5678, 1);
    check("drop_next", imem_addr, 32'h0000_0200);
    check("drop_valid", 32'(if_valid), 32'h0);

    // PC wrap, then reset mid-WAIT
    step(0, 1, 1, 32'hFFFF_FFFC, 0, 0, 32'h0, 1);
    step(0, 1, 0, 0, 0, 0, 32'h0C00_0000, 1);
    check("wrap_addr", imem_addr, 32'h0);
    check("wrap_pc4", if_pc_plus4, 32'h0);
    step(0, 0, 0, 0, 0, 0, 32'h0, 1);
    step(0, 0, 0, 0, 0, 0, 32'h0, 0);
    check("midrst_addr", imem_addr, 32'h0);
    check("midrst_valid", 32'(if_valid), 32'h0);

`ifdef FETCH_REDIRECT_CNT_EN
    for (int k = 0; k < 3; k++) step(0, 1, 1, 32'h20, 0, 0, 32'h0, 1);
    check("cnt_three", 32'(redirect_cnt), 32'd3);
`endif

    // Randomized run against the model
    verbose = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      step(($urandom % 4) == 0, ($urandom % 10) < 7, ($urandom % 12) == 0,
           $urandom & 32'hFFFF_FFFC, ($urandom % 12) == 0, 26'($urandom), $urandom,
           ($urandom % 100) != 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
